// File: rtl/oled_cmd_arbiter_if.sv
// oled_cmd_arbiter_if: requester/controller bundle (req, op, arg, ready in; ack, done, err, busy, grant_id, showchar, showbmp, clear, sw out)
interface oled_cmd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [2*N_REQ-1:0] op;
  logic [16*N_REQ-1:0] arg;
  logic [N_REQ-1:0] ack;
  logic [N_REQ-1:0] done;
  logic err;
  logic busy;
  logic [2:0] grant_id;
  logic showchar;
  logic showbmp;
  logic clear;
  logic [15:0] sw;
  logic ready;
  modport master (
    output req, op, arg, ready,
    input ack, done, err, busy, grant_id, showchar, showbmp, clear, sw
  );
  modport slave (
    input req, op, arg, ready,
    output ack, done, err, busy, grant_id, showchar, showbmp, clear, sw
  );
endinterface

// File: rtl/oled_cmd_arbiter.sv
// oled_cmd_arbiter: round-robin share of the OLED command port; ports clk, rst, bus (oled_cmd_arbiter_if.slave); macro OLED_ARB_PRIO_CLEAR_EN lets clear requests win
module oled_cmd_arbiter #(
  parameter int N_REQ = 4,
  parameter int BUSY_TIMEOUT = 1023
) (
  input logic clk,
  input logic rst,
  oled_cmd_arbiter_if.slave bus
);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_READY, DONE} state_t;
  state_t state, state_nx;
  logic [2:0] rr, g, win;
  logic [N_REQ-1:0] cand;
  logic [1:0] wop;
  logic [CW-1:0] cnt;
  logic eflag, launch;
`ifdef OLED_ARB_PRIO_CLEAR_EN
  logic [N_REQ-1:0] clr;
`endif
  assign launch = |bus.ack;
  assign wop = bus.op[{win, 1'b0} +: 2];
  always_comb begin
    cand = bus.req;
`ifdef OLED_ARB_PRIO_CLEAR_EN
    for (int i = 0; i < N_REQ; i++) clr[i] = bus.op[2*i +: 2] == 2'b10;
    if (|(bus.req & clr)) cand = bus.req & clr;
`endif
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (cand[(int'(rr) + k) % N_REQ]) win = 3'((int'(rr) + k) % N_REQ);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = bus.ready && |bus.req ? WAIT_BUSY : IDLE;
      WAIT_BUSY:  state_nx = launch ? (eflag ? DONE : WAIT_BUSY) :
                             !bus.ready ? WAIT_READY :
                             cnt == CW'(BUSY_TIMEOUT) ? DONE : WAIT_BUSY;
      WAIT_READY: state_nx = bus.ready ? DONE : WAIT_READY;
      default:    state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      g <= '0;
      cnt <= '0;
      eflag <= 1'b0;
      bus.ack <= '0;
      bus.showchar <= 1'b0;
      bus.showbmp <= 1'b0;
      bus.clear <= 1'b0;
      bus.sw <= '0;
    end else begin
      state <= state_nx;
      bus.ack <= '0;
      bus.showchar <= 1'b0;
      bus.showbmp <= 1'b0;
      bus.clear <= 1'b0;
      cnt <= state == DONE ? '0 : state == WAIT_BUSY && !launch && bus.ready ? cnt + 1'b1 : cnt;
      if (state == IDLE && state_nx == WAIT_BUSY) begin
        g <= win;
        bus.ack <= N_REQ'(1) << win;
        bus.sw <= bus.arg[{win, 4'b0} +: 16];
        eflag <= wop == 2'b11;
        bus.showchar <= wop == 2'b00;
        bus.showbmp <= wop == 2'b01;
        bus.clear <= wop == 2'b10;
      end else if (state == WAIT_BUSY && !launch && state_nx == DONE) begin
        eflag <= 1'b1;
      end
      if (state == DONE) rr <= g == 3'(N_REQ - 1) ? 3'd0 : g + 3'd1;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE ? N_REQ'(1) << g : '0;
  assign bus.err = state == DONE && eflag;
  assign bus.grant_id = g;
endmodule
